// File: rtl/serial_pkg.sv
// Shared sizing for the serial slave: default word-width exponent and the
// derived word and bit-counter widths.
package serial_pkg;

    localparam int DATA_WIDTH_BASE_DEF = 5;

    function automatic int word_width(input int base);
        return 2 ** base;
    endfunction

    // One extra bit so the counter can hold the full-word value W itself.
    function automatic int cnt_width(input int base);
        return base + 1;
    endfunction

endpackage

// File: rtl/serial_slave_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, with a single-clk
// rising-edge pulse derived from the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;
    logic stable;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= din;
            stable <= meta;
            prev   <= stable;
        end
    end

    assign level = stable;
    assign rise  = stable & ~prev;

endmodule

// File: rtl/serial_slave.sv
// Full-duplex serial slave: MSB-first receive on sck_m2s, LSB-first transmit
// on sck_s2m, framed by latch_in. Define SERIAL_SLAVE_FRAME_CHECK_EN to enable
// the frame-length check that drives frame_err.
module serial_slave
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH_BASE = DATA_WIDTH_BASE_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sck_m2s,
    input  logic                            data_m2s,
    input  logic                            sck_s2m,
    output logic                            data_s2m,
    input  logic                            latch_in,
    output logic [(2**DATA_WIDTH_BASE)-1:0] rx_word,
    output logic                            rx_valid,
    input  logic [(2**DATA_WIDTH_BASE)-1:0] tx_word,
    output logic                            frame_err
);

    localparam int W  = word_width(DATA_WIDTH_BASE);
    localparam int CW = cnt_width(DATA_WIDTH_BASE);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    logic m2s_sck_rise;
    logic m2s_data_lvl;
    logic s2m_sck_rise;
    logic latch_rise;
    logic m2s_sck_lvl_unused;
    logic m2s_data_rise_unused;
    logic s2m_sck_lvl_unused;
    logic latch_lvl_unused;

    sync_edge u_sync_sck_m2s (
        .clk   (clk),
        .rst   (rst),
        .din   (sck_m2s),
        .level (m2s_sck_lvl_unused),
        .rise  (m2s_sck_rise)
    );

    sync_edge u_sync_data_m2s (
        .clk   (clk),
        .rst   (rst),
        .din   (data_m2s),
        .level (m2s_data_lvl),
        .rise  (m2s_data_rise_unused)
    );

    sync_edge u_sync_sck_s2m (
        .clk   (clk),
        .rst   (rst),
        .din   (sck_s2m),
        .level (s2m_sck_lvl_unused),
        .rise  (s2m_sck_rise)
    );

    sync_edge u_sync_latch (
        .clk   (clk),
        .rst   (rst),
        .din   (latch_in),
        .level (latch_lvl_unused),
        .rise  (latch_rise)
    );

    logic [W-1:0]               rx_shift;
    logic [W-1:0]               tx_shift;
    logic [CW-1:0]              rx_cnt;
    logic [CW-1:0]              tx_cnt;
    logic [DATA_WIDTH_BASE-1:0] tx_idx;
    logic                       rx_step;
    logic                       tx_step;
    logic                       vld_p1;

    // A latch in the same clk as a serial edge swallows that edge on both channels.
    always_comb begin
        rx_step = m2s_sck_rise & ~latch_rise;
        tx_step = s2m_sck_rise & ~latch_rise;
        tx_idx  = tx_cnt[DATA_WIDTH_BASE-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift <= '0;
            rx_cnt   <= '0;
            rx_word  <= '0;
        end else if (latch_rise) begin
            rx_word <= rx_shift;
            rx_cnt  <= '0;
        end else if (rx_step) begin
            rx_shift <= {rx_shift[W-2:0], m2s_data_lvl};
            if (rx_cnt != CNT_FULL) begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // Bit 0 goes out straight from tx_word so it is valid on the first clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            data_s2m <= 1'b0;
        end else if (latch_rise) begin
            tx_cnt <= '0;
        end else if (tx_step) begin
            if (tx_cnt == '0) begin
                tx_shift <= tx_word;
                data_s2m <= tx_word[0];
                tx_cnt   <= {{(CW-1){1'b0}}, 1'b1};
            end else if (tx_cnt < CNT_FULL) begin
                data_s2m <= tx_shift[tx_idx];
                tx_cnt   <= tx_cnt + 1'b1;
            end else begin
                data_s2m <= 1'b0;
            end
        end
    end

    // ---- stage p1: latch seen, rx_word loaded; stage p2: strobes out ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            vld_p1   <= latch_rise;
            rx_valid <= vld_p1;
        end
    end

`ifdef SERIAL_SLAVE_FRAME_CHECK_EN
    logic frame_bad;
    logic err_p1;

    always_comb begin
        frame_bad = (rx_cnt != CNT_FULL) || ((tx_cnt != '0) && (tx_cnt != CNT_FULL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_p1    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            err_p1    <= latch_rise & frame_bad;
            frame_err <= err_p1;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_slave.sv
// Self-checking bench for serial_slave: table of full-frame vectors plus
// hand-written partial-frame, underrun, collision and mid-frame reset cases.
module tb_serial_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck_m2s = 1'b0;
    logic        data_m2s = 1'b0;
    logic        sck_s2m = 1'b0;
    logic        data_s2m;
    logic        latch_in = 1'b0;
    logic [31:0] rx_word;
    logic        rx_valid;
    logic [31:0] tx_word = '0;
    logic        frame_err;

    serial_slave #(.DATA_WIDTH_BASE(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck_m2s   (sck_m2s),
        .data_m2s  (data_m2s),
        .sck_s2m   (sck_s2m),
        .data_s2m  (data_s2m),
        .latch_in  (latch_in),
        .rx_word   (rx_word),
        .rx_valid  (rx_valid),
        .tx_word   (tx_word),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rx;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] rx_in;
        logic [31:0] tx_in;
        int          n_rx;
        int          n_tx;
        logic [31:0] exp_rx;
        logic [31:0] exp_tx;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    logic [31:0] m_rx_shift = '0;
    int          m_rx_cnt = 0;
    int          m_tx_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_err(input int rc, input int tc);
`ifdef SERIAL_SLAVE_FRAME_CHECK_EN
        return (rc != 32) || ((tc != 0) && (tc != 32));
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_rx_valid", rx_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_word", rx_word, mon_e.rx);
                chk("frame_err", frame_err, mon_e.err);
            end
        end else if (frame_err) begin
            chk("stray_frame_err", frame_err, 0);
        end
    end

    task automatic send_m2s(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            data_m2s = w[31-i];
            repeat (4) @(negedge clk);
            sck_m2s = 1'b1;
            m_rx_shift = {m_rx_shift[30:0], w[31-i]};
            if (m_rx_cnt < 32) m_rx_cnt++;
            repeat (4) @(negedge clk);
            sck_m2s = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic recv_s2m(input int n, output logic [63:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            sck_s2m = 1'b1;
            if (m_tx_cnt < 32) m_tx_cnt++;
            repeat (4) @(negedge clk);
            cap[i] = data_s2m;
            sck_s2m = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic do_latch(input logic [31:0] exp_rx, input logic with_sck);
        exp_t e;
        int   v0;
        e.rx  = exp_rx;
        e.err = exp_err(m_rx_cnt, m_tx_cnt);
        sb.push_back(e);
        v0 = n_valid;
        latch_in = 1'b1;
        if (with_sck) begin
            sck_m2s  = 1'b1;
            sck_s2m  = 1'b1;
            data_m2s = 1'b1;
        end
        m_rx_cnt = 0;
        m_tx_cnt = 0;
        repeat (4) @(negedge clk);
        latch_in = 1'b0;
        sck_m2s  = 1'b0;
        sck_s2m  = 1'b0;
        data_m2s = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        chk("latch_drain", sb.size(), 0);
        sb.delete();
        repeat (4) @(negedge clk);
        chk("rx_valid_count", n_valid - v0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        logic [63:0] cap;
        logic        c1, c2, c3;

        tbl[0] = '{32'd1_456_478_547, 32'h0,          32, 0,  32'd1_456_478_547, 32'h0};
        tbl[1] = '{32'h0,             32'd1_456_478_547, 0, 32, 32'd1_456_478_547, 32'd1_456_478_547};
        tbl[2] = '{32'hA5A5_0F0F,     32'h1234_5678,  32, 32, 32'hA5A5_0F0F,     32'h1234_5678};
        tbl[3] = '{32'h8000_0001,     32'hFFFF_FFFF,  32, 32, 32'h8000_0001,     32'hFFFF_FFFF};
        tbl[4] = '{32'h0000_0000,     32'h8000_0000,  32, 32, 32'h0000_0000,     32'h8000_0000};

        repeat (3) @(negedge clk);
        chk("reset_rx_word", rx_word, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_data_s2m", data_s2m, 0);
        chk("reset_frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            tx_word = tbl[v].tx_in;
            cap = '0;
            fork
                begin
                    if (tbl[v].n_rx > 0) send_m2s(tbl[v].rx_in, tbl[v].n_rx);
                end
                begin
                    if (tbl[v].n_tx > 0) recv_s2m(tbl[v].n_tx, cap);
                end
            join
            if (tbl[v].n_tx > 0) chk($sformatf("tx_word_vec%0d", v), cap[31:0], tbl[v].exp_tx);
            do_latch(tbl[v].exp_rx, 1'b0);
        end

        // Short receive frame: 31 edges leaves one stale bit at the top.
        send_m2s(32'hDEAD_BEEC, 31);
        do_latch(m_rx_shift, 1'b0);

        // Transmit underrun: pulses beyond 32 read 0.
        tx_word = 32'hCAFE_F00D;
        recv_s2m(34, cap);
        chk("underrun_word", cap[31:0], 32'hCAFE_F00D);
        chk("underrun_bit32", cap[32], 0);
        chk("underrun_bit33", cap[33], 0);
        do_latch(m_rx_shift, 1'b0);

        // Latch collides with both serial edges; those edges must vanish.
        do_latch(m_rx_shift, 1'b1);
        tx_word = 32'h1357_9BDF;
        fork
            send_m2s(32'hFFFF_FFFE, 31);
            recv_s2m(32, cap);
        join
        chk("collision_tx_word", cap[31:0], 32'h1357_9BDF);
        do_latch(m_rx_shift, 1'b0);

        // Mid-frame reset after 10 bits on each channel.
        tx_word = 32'h0000_0200;
        fork
            send_m2s(32'hFFFF_FFFF, 10);
            recv_s2m(10, cap);
        join
        chk("pre_reset_data_s2m", data_s2m, 1);
        chk("pre_reset_rx_word", rx_word, 32'h7FFF_FFFF);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_rx_word", rx_word, 0);
        chk("async_rst_rx_valid", rx_valid, 0);
        chk("async_rst_data_s2m", data_s2m, 0);
        chk("async_rst_frame_err", frame_err, 0);
        m_rx_shift = '0;
        m_rx_cnt = 0;
        m_tx_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // First pulse after reset: data_s2m must change on the third clk.
        tx_word = 32'd7;
        sck_s2m = 1'b1;
        m_tx_cnt = 1;
        @(negedge clk); c1 = data_s2m;
        @(negedge clk); c2 = data_s2m;
        @(negedge clk); c3 = data_s2m;
        @(negedge clk);
        sck_s2m = 1'b0;
        repeat (4) @(negedge clk);
        chk("latency_clk1", c1, 0);
        chk("latency_clk2", c2, 0);
        chk("latency_clk3", c3, 1);
        recv_s2m(31, cap);
        chk("post_reset_tx_word", {cap[30:0], c3}, 32'd7);
        send_m2s(32'd7, 32);
        do_latch(32'd7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
